// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE / BURST)
//   STAT_W      : width of the per-requester accepted-beat counters, which are
//                 only present when FIFO_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-set finder.
// Starting at index ptr and walking upward modulo NUM_REQ, it returns the first
// requester whose req bit is set.
//   req : request vector
//   ptr : search start index (round-robin pointer)
//   sel : index of the first set request at or after ptr (0 when none)
//   any : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     sel,
  output logic               any
);

  int idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      // The first hit wins; later hits in the walk are ignored.
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin write arbiter sharing one synchronous FIFO write port between
// NUM_REQ producers. A granted producer keeps the port for up to BURST_LEN
// beats; acceptance is zero-latency (ack, fifo_wr_en and fifo_wr_data are
// combinational from the current state and inputs).
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high
//   req          : per-requester beat valid
//   req_data     : packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          : one-hot, beat from requester i accepted this cycle
//   fifo_full    : FIFO full flag
//   fifo_wr_en   : FIFO write enable (== |ack)
//   fifo_wr_data : FIFO write data (0 when not writing)
//   busy         : high while in BURST
//   owner_id     : current / last granted requester
//
// Optional feature, macro FIFO_ARB_STATS_EN:
//   stat_sel : requester whose counter is read
//   stat_cnt : combinational read of that requester's 16-bit saturating
//              accepted-beat counter
//   stat_clr : synchronously zeroes all counters (wins over a same-cycle
//              accept); rst also clears them
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          busy,
  output logic [IDW-1:0]                owner_id
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]                stat_sel,
  output logic [STAT_W-1:0]             stat_cnt,
  input  logic                          stat_clr
`endif
);

  localparam int BCW = $clog2(BURST_LEN + 1);

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [BCW-1:0] beat_cnt;

  logic [IDW-1:0] pick_sel;
  logic           pick_any;
  logic [IDW-1:0] sel;
  logic           sel_req;
  logic           accept;
  logic           burst_done;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

  // In BURST only the owner is eligible; in IDLE the round-robin pick is used.
  // Reset masks acceptance so nothing is written in the reset cycle.
  always_comb begin
    sel          = (state == BURST) ? owner : pick_sel;
    sel_req      = (state == BURST) ? req[owner] : pick_any;
    accept       = !rst && sel_req && !fifo_full;
    ack          = '0;
    fifo_wr_data = '0;
    if (accept) begin
      ack[sel]     = 1'b1;
      fifo_wr_data = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr_en = accept;
  assign burst_done = (beat_cnt + 1'b1) == BCW'(BURST_LEN);
  assign busy       = (state == BURST);
  assign owner_id   = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner <= sel;
            if (BURST_LEN == 1) begin
              rr_ptr <= next_idx(sel);
            end else begin
              state    <= BURST;
              beat_cnt <= BCW'(1);
            end
          end
        end
        BURST: begin
          // Owner withdrawing ends the burst even while the FIFO is full.
          if (!req[owner]) begin
            state    <= IDLE;
            rr_ptr   <= next_idx(owner);
            beat_cnt <= '0;
          end else if (accept) begin
            if (burst_done) begin
              state    <= IDLE;
              rr_ptr   <= next_idx(owner);
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          // fifo_full with req held: stall, ownership and beat_cnt frozen.
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || stat_clr) begin
        stat_q[i] <= '0;
      end else if (ack[i] && (stat_q[i] != '1)) begin
        stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  // Indices beyond NUM_REQ-1 (non power-of-two NUM_REQ) read as zero.
  assign stat_cnt = (int'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter. A main instance (BURST_LEN=4) is
// driven from a table of hand-derived vectors; a second instance with
// BURST_LEN=1 covers the single-beat rotation case. Expected records are
// queued when stimulus is driven and popped when outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] req_data;
  logic           fifo_full;

  logic [NR-1:0]  ack,  ack1;
  logic           wr_en, wr_en1;
  logic [DW-1:0]  wr_data, wr_data1;
  logic           busy, busy1;
  logic [1:0]     owner_id, owner_id1;

`ifdef FIFO_ARB_STATS_EN
  logic [1:0]        stat_sel, stat_sel1;
  logic [STAT_W-1:0] stat_cnt, stat_cnt1;
  logic              stat_clr;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (wr_en),
    .fifo_wr_data (wr_data),
    .busy         (busy),
    .owner_id     (owner_id)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_cnt     (stat_cnt),
    .stat_clr     (stat_clr)
`endif
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack1),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (wr_en1),
    .fifo_wr_data (wr_data1),
    .busy         (busy1),
    .owner_id     (owner_id1)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel     (stat_sel1),
    .stat_cnt     (stat_cnt1),
    .stat_clr     (stat_clr)
`endif
  );

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic          full;
    logic [NR-1:0] ack;
    logic          busy;
    logic [1:0]    owner;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [NR-1:0] rq, input logic f,
                     input logic [NR-1:0] a, input logic b, input logic [1:0] o);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.ack = a; v.busy = b; v.owner = o;
    tbl.push_back(v);
  endtask

  // Expected write data follows from the expected ack: source i sends A0+i.
  function automatic logic [DW-1:0] exp_data(input logic [NR-1:0] a);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < NR; i++) if (a[i]) d = 8'hA0 + DW'(i);
    return d;
  endfunction

  task automatic apply(input vec_t v, input int n);
    vec_t e;
    @(posedge clk);
    #1;
    rst       = v.rst;
    req       = v.req;
    fifo_full = v.full;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("v%0d_ack", n),   32'(ack),     32'(e.ack));
    chk($sformatf("v%0d_wr_en", n), 32'(wr_en),   32'(|e.ack));
    chk($sformatf("v%0d_data", n),  32'(wr_data), 32'(exp_data(e.ack)));
    chk($sformatf("v%0d_busy", n),  32'(busy),    32'(e.busy));
    chk($sformatf("v%0d_owner", n), 32'(owner_id), 32'(e.owner));
  endtask

  localparam int SPLIT = 18;

  initial begin
    logic [NR-1:0] exp1 [4];

    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
`ifdef FIFO_ARB_STATS_EN
    stat_sel  = '0;
    stat_sel1 = '0;
    stat_clr  = 1'b0;
`endif

    // Reset held with all requests up: nothing accepted, registers at 0.
    add(1, 4'b1111, 0, 4'b0000, 0, 2'd0);
    // Four-beat bursts rotating 0 -> 1 -> 2 -> 3.
    add(0, 4'b1111, 0, 4'b0001, 0, 2'd0);
    add(0, 4'b1111, 0, 4'b0001, 1, 2'd0);
    add(0, 4'b1111, 0, 4'b0001, 1, 2'd0);
    add(0, 4'b1111, 0, 4'b0001, 1, 2'd0);
    add(0, 4'b1111, 0, 4'b0010, 0, 2'd0);
    add(0, 4'b1111, 0, 4'b0010, 1, 2'd1);
    add(0, 4'b1111, 0, 4'b0010, 1, 2'd1);
    add(0, 4'b1111, 0, 4'b0010, 1, 2'd1);
    add(0, 4'b1111, 0, 4'b0100, 0, 2'd1);
    add(0, 4'b1111, 0, 4'b0100, 1, 2'd2);
    add(0, 4'b1111, 0, 4'b0100, 1, 2'd2);
    add(0, 4'b1111, 0, 4'b0100, 1, 2'd2);
    add(0, 4'b1111, 0, 4'b1000, 0, 2'd2);
    add(0, 4'b1111, 0, 4'b1000, 1, 2'd3);
    add(0, 4'b1111, 0, 4'b1000, 1, 2'd3);
    add(0, 4'b1111, 0, 4'b1000, 1, 2'd3);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3);
    // Burst by req1 stalled by fifo_full for 3 cycles, beat count frozen.
    add(0, 4'b0110, 0, 4'b0010, 0, 2'd3);
    add(0, 4'b0110, 0, 4'b0010, 1, 2'd1);
    add(0, 4'b0110, 1, 4'b0000, 1, 2'd1);
    add(0, 4'b0110, 1, 4'b0000, 1, 2'd1);
    add(0, 4'b0110, 1, 4'b0000, 1, 2'd1);
    add(0, 4'b0110, 0, 4'b0010, 1, 2'd1);
    add(0, 4'b0110, 0, 4'b0010, 1, 2'd1);
    // req2 takes over, drops after 2 beats; req3 granted next.
    add(0, 4'b0110, 0, 4'b0100, 0, 2'd1);
    add(0, 4'b1100, 0, 4'b0100, 1, 2'd2);
    add(0, 4'b1000, 0, 4'b0000, 1, 2'd2);
    add(0, 4'b1000, 0, 4'b1000, 0, 2'd2);
    // Reset during req3 burst; afterwards lowest active requester wins.
    add(0, 4'b1001, 0, 4'b1000, 1, 2'd3);
    add(1, 4'b1001, 0, 4'b0000, 1, 2'd3);
    add(0, 4'b1001, 0, 4'b0001, 0, 2'd0);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd0);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd0);

    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < SPLIT; i++) apply(tbl[i], i);

`ifdef FIFO_ARB_STATS_EN
    // Each requester got exactly 4 beats in the rotation above.
    for (int s = 0; s < NR; s++) begin
      stat_sel = 2'(s);
      #1;
      chk($sformatf("stat_cnt%0d", s), 32'(stat_cnt), 32'd4);
    end
    @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    for (int s = 0; s < NR; s++) begin
      stat_sel = 2'(s);
      #1;
      chk($sformatf("stat_clr%0d", s), 32'(stat_cnt), 32'd0);
    end
`endif

    for (int i = SPLIT; i < tbl.size(); i++) apply(tbl[i], i);

    // Single-beat instance: req0/req2 alternate every cycle.
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0101;
    exp1[0] = 4'b0001;
    exp1[1] = 4'b0100;
    exp1[2] = 4'b0001;
    exp1[3] = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b1_ack%0d", k),   32'(ack1),     32'(exp1[k]));
      chk($sformatf("b1_wr_en%0d", k), 32'(wr_en1),   32'd1);
      chk($sformatf("b1_data%0d", k),  32'(wr_data1), 32'(exp_data(exp1[k])));
      chk($sformatf("b1_busy%0d", k),  32'(busy1),    32'd0);
      @(posedge clk);
    end
    #1 req = '0;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
